// File: rtl/cache_line_evict_fill.sv
// ---------------------------------------------------------------------------
// cache_line_evict_fill
//
// Carries out a cache line replacement once the replacement block has chosen
// a victim way. If the victim is dirty it is written back to memory beat by
// beat; the missing line is then fetched beat by beat, assembled, and written
// into the victim way with a single array strobe. The replacement block is
// told to update its state by a pulse that coincides with that strobe.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   MissReq             start a replacement (only looked at while idle)
//   MissTag, MissSet    address of the missing line
//   VictimWay           one-hot way to replace (passed through unchecked)
//   VictimDirty         victim needs a writeback
//   VictimTag           tag of the victim line (writeback address)
//   VictimLine          victim line data, valid in the MissReq cycle
//   Busy                high whenever a replacement is in progress
//   BusReq, BusWrite    beat request; BusWrite=1 writeback, 0 fill
//   BusAdr, BusWData    beat address and writeback data
//   BusReady, BusRData  beat accepted / fill data valid, fill data
//   LineWrEn..Data      one-cycle array write of the assembled line
//   LRUWriteEn          one-cycle pulse together with LineWrEn
//   Done                one-cycle pulse the cycle after LineWrEn
// ---------------------------------------------------------------------------
module cache_line_evict_fill #(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 7,
  parameter int TAGLEN    = 19,
  parameter int OFFSETLEN = 6,
  parameter int BEATLEN   = 64,
  localparam int LINELEN    = 8 * (2 ** OFFSETLEN),
  localparam int BEATS      = LINELEN / BEATLEN,
  // A single-beat line still gets a 1-bit counter; it never leaves zero.
  localparam int BEATCNTLEN = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int PA_BITS    = TAGLEN + SETLEN + OFFSETLEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MissReq,
  input  logic [TAGLEN-1:0]    MissTag,
  input  logic [SETLEN-1:0]    MissSet,
  input  logic [NUMWAYS-1:0]   VictimWay,
  input  logic                 VictimDirty,
  input  logic [TAGLEN-1:0]    VictimTag,
  input  logic [LINELEN-1:0]   VictimLine,
  output logic                 Busy,
  output logic                 BusReq,
  output logic                 BusWrite,
  output logic [PA_BITS-1:0]   BusAdr,
  output logic [BEATLEN-1:0]   BusWData,
  input  logic                 BusReady,
  input  logic [BEATLEN-1:0]   BusRData,
  output logic                 LineWrEn,
  output logic [NUMWAYS-1:0]   LineWrWay,
  output logic [SETLEN-1:0]    LineWrSet,
  output logic [TAGLEN-1:0]    LineWrTag,
  output logic [LINELEN-1:0]   LineWrData,
  output logic                 LRUWriteEn,
  output logic                 Done
);

  localparam int LINEIDXW  = $clog2(LINELEN);
  localparam int BEATSHIFT = $clog2(BEATLEN);
  localparam int BYTESHIFT = $clog2(BEATLEN / 8);
  localparam logic [BEATCNTLEN-1:0] LAST_BEAT = BEATCNTLEN'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BEATCNTLEN-1:0] cnt_q, cnt_d;
  logic [TAGLEN-1:0]    miss_tag_q, miss_tag_d;
  logic [SETLEN-1:0]    set_q, set_d;
  logic [NUMWAYS-1:0]   way_q, way_d;
  logic [TAGLEN-1:0]    victim_tag_q, victim_tag_d;
  logic [LINELEN-1:0]   victim_line_q, victim_line_d;
  logic [LINELEN-1:0]   fill_line_q, fill_line_d;

  // Bit position of the current beat inside a line, and its byte offset
  // inside the line address. Beat 0 occupies the line LSBs.
  logic [LINEIDXW-1:0]  beat_base;
  logic [OFFSETLEN-1:0] beat_ofs;
  logic                 last_beat;

  assign beat_base = LINEIDXW'(cnt_q) << BEATSHIFT;
  assign beat_ofs  = OFFSETLEN'(cnt_q) << BYTESHIFT;
  assign last_beat = (cnt_q == LAST_BEAT);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      miss_tag_q    <= '0;
      set_q         <= '0;
      way_q         <= '0;
      victim_tag_q  <= '0;
      victim_line_q <= '0;
      fill_line_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      miss_tag_q    <= miss_tag_d;
      set_q         <= set_d;
      way_q         <= way_d;
      victim_tag_q  <= victim_tag_d;
      victim_line_q <= victim_line_d;
      fill_line_q   <= fill_line_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    miss_tag_d    = miss_tag_q;
    set_d         = set_q;
    way_d         = way_q;
    victim_tag_d  = victim_tag_q;
    victim_line_d = victim_line_q;
    fill_line_d   = fill_line_q;

    case (state_q)
      S_IDLE: begin
        if (MissReq) begin
          miss_tag_d    = MissTag;
          set_d         = MissSet;
          way_d         = VictimWay;
          victim_tag_d  = VictimTag;
          victim_line_d = VictimLine;
          cnt_d         = '0;
          // Dirtiness only selects the first state, so it needs no register.
          state_d       = VictimDirty ? S_WB : S_FILL;
        end
      end

      S_WB: begin
        if (BusReady) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_FILL: begin
        if (BusReady) begin
          fill_line_d[beat_base +: BEATLEN] = BusRData;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_WRITE: state_d = S_DONE;

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: pure functions of the registers, so they hold steady across
  // bus stalls without extra logic.
  // -------------------------------------------------------------------------
  always_comb begin
    Busy       = (state_q != S_IDLE);
    BusReq     = 1'b0;
    BusWrite   = 1'b0;
    BusAdr     = '0;
    BusWData   = '0;
    LineWrEn   = 1'b0;
    LRUWriteEn = 1'b0;
    Done       = 1'b0;

    case (state_q)
      S_WB: begin
        BusReq   = 1'b1;
        BusWrite = 1'b1;
        BusAdr   = {victim_tag_q, set_q, beat_ofs};
        BusWData = victim_line_q[beat_base +: BEATLEN];
      end
      S_FILL: begin
        BusReq = 1'b1;
        BusAdr = {miss_tag_q, set_q, beat_ofs};
      end
      S_WRITE: begin
        LineWrEn   = 1'b1;
        LRUWriteEn = 1'b1;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign LineWrWay  = way_q;
  assign LineWrSet  = set_q;
  assign LineWrTag  = miss_tag_q;
  assign LineWrData = fill_line_q;

endmodule

// File: tb/tb_cache_line_evict_fill.sv
// ---------------------------------------------------------------------------
// Testbench for cache_line_evict_fill: default 8-beat instance plus a
// single-beat (BEATLEN=512) instance. Directed scenarios, one task each.
// ---------------------------------------------------------------------------
module tb_cache_line_evict_fill;

  logic          clk = 1'b0;
  logic          reset;
  logic          MissReq, MissReq1;
  logic [18:0]   MissTag;
  logic [6:0]    MissSet;
  logic [3:0]    VictimWay;
  logic          VictimDirty;
  logic [18:0]   VictimTag;
  logic [511:0]  VictimLine;
  logic          BusReady, BusReady1;
  logic [63:0]   BusRData;
  logic [511:0]  BusRData1;

  logic          Busy, BusReq, BusWrite, LineWrEn, LRUWriteEn, Done;
  logic [31:0]   BusAdr;
  logic [63:0]   BusWData;
  logic [3:0]    LineWrWay;
  logic [6:0]    LineWrSet;
  logic [18:0]   LineWrTag;
  logic [511:0]  LineWrData;

  logic          Busy1, BusReq1, BusWrite1, LineWrEn1, LRUWriteEn1, Done1;
  logic [31:0]   BusAdr1;
  logic [511:0]  BusWData1;
  logic [3:0]    LineWrWay1;
  logic [6:0]    LineWrSet1;
  logic [18:0]   LineWrTag1;
  logic [511:0]  LineWrData1;

  int vec_count = 0;
  int err_count = 0;

  cache_line_evict_fill dut (
    .clk(clk), .reset(reset), .MissReq(MissReq), .MissTag(MissTag),
    .MissSet(MissSet), .VictimWay(VictimWay), .VictimDirty(VictimDirty),
    .VictimTag(VictimTag), .VictimLine(VictimLine), .Busy(Busy),
    .BusReq(BusReq), .BusWrite(BusWrite), .BusAdr(BusAdr),
    .BusWData(BusWData), .BusReady(BusReady), .BusRData(BusRData),
    .LineWrEn(LineWrEn), .LineWrWay(LineWrWay), .LineWrSet(LineWrSet),
    .LineWrTag(LineWrTag), .LineWrData(LineWrData),
    .LRUWriteEn(LRUWriteEn), .Done(Done)
  );

  cache_line_evict_fill #(.BEATLEN(512)) dut1 (
    .clk(clk), .reset(reset), .MissReq(MissReq1), .MissTag(MissTag),
    .MissSet(MissSet), .VictimWay(VictimWay), .VictimDirty(VictimDirty),
    .VictimTag(VictimTag), .VictimLine(VictimLine), .Busy(Busy1),
    .BusReq(BusReq1), .BusWrite(BusWrite1), .BusAdr(BusAdr1),
    .BusWData(BusWData1), .BusReady(BusReady1), .BusRData(BusRData1),
    .LineWrEn(LineWrEn1), .LineWrWay(LineWrWay1), .LineWrSet(LineWrSet1),
    .LineWrTag(LineWrTag1), .LineWrData(LineWrData1),
    .LRUWriteEn(LRUWriteEn1), .Done(Done1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 unit after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Physical beat address: tag<<13 | set<<6 | beat*8 (8-byte beats).
  function automatic logic [31:0] exp_adr(input logic [18:0] tag,
                                          input logic [6:0] set,
                                          input int beat);
    return ({13'b0, tag} << 13) | ({25'b0, set} << 6) | 32'(beat * 8);
  endfunction

  function automatic logic [63:0] fill_word(input int i);
    return 64'hF1F1_2345_0000_0000 + 64'(i * 3 + 1);
  endfunction

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    #1;
    vec_count++;
    if ({Busy, BusReq, BusWrite, BusAdr, BusWData, LineWrEn, LRUWriteEn, Done} !== '0)
      begin err_count++; $display("FAIL reset_bus: got %h expected 0",
        {Busy, BusReq, BusWrite, BusAdr, BusWData, LineWrEn, LRUWriteEn, Done}); end
    vec_count++;
    if ({LineWrWay, LineWrSet, LineWrTag} !== '0 || LineWrData !== '0)
      begin err_count++; $display("FAIL reset_latched: got way %h set %h tag %h data!=0:%0d",
        LineWrWay, LineWrSet, LineWrTag, LineWrData != '0); end
    repeat (2) tick();
    vec_count++;
    if ({Busy1, BusReq1, LineWrEn1, Done1, BusAdr1} !== '0)
      begin err_count++; $display("FAIL reset_dut1: got %h expected 0",
        {Busy1, BusReq1, LineWrEn1, Done1, BusAdr1}); end
    reset = 1'b0;
    tick();
    $display("reset: done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_clean_miss();
    logic [511:0] exp_line;
    MissTag = 19'h01234; MissSet = 7'h05; VictimWay = 4'b0100;
    VictimDirty = 1'b0; VictimTag = 19'h30000; VictimLine = {16{32'hDEAD_BEEF}};
    MissReq = 1'b1;
    tick();                                   // cycle t+1
    MissReq = 1'b0; BusReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      BusRData = fill_word(i);
      exp_line[i*64 +: 64] = fill_word(i);
      vec_count++;
      if ({Busy, BusReq, BusWrite, LineWrEn, Done, BusAdr} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_adr(19'h01234, 7'h05, i)})
        begin err_count++; $display("FAIL clean_fill beat %0d: got %h expected %h", i,
          {Busy, BusReq, BusWrite, LineWrEn, Done, BusAdr},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_adr(19'h01234, 7'h05, i)}); end
      tick();
    end
    BusReady = 1'b0;                          // cycle t+9
    vec_count++;
    if ({LineWrEn, LRUWriteEn, BusReq, Done, LineWrWay, LineWrSet, LineWrTag} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 7'h05, 19'h01234})
      begin err_count++; $display("FAIL clean_write: got %h expected %h",
        {LineWrEn, LRUWriteEn, BusReq, Done, LineWrWay, LineWrSet, LineWrTag},
        {1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 7'h05, 19'h01234}); end
    vec_count++;
    if (LineWrData !== exp_line)
      begin err_count++; $display("FAIL clean_data: got %h expected %h", LineWrData, exp_line); end
    tick();                                   // cycle t+10
    vec_count++;
    if ({Done, Busy, LineWrEn, LRUWriteEn} !== 4'b1100)
      begin err_count++; $display("FAIL clean_done: got %b expected 1100",
        {Done, Busy, LineWrEn, LRUWriteEn}); end
    tick();
    vec_count++;
    if ({Busy, Done} !== 2'b00)
      begin err_count++; $display("FAIL clean_idle: got %b expected 00", {Busy, Done}); end
    $display("clean_miss: done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_dirty_miss();
    logic [511:0] exp_line;
    MissTag = 19'h54321; MissSet = 7'h7F; VictimWay = 4'b1000;
    VictimDirty = 1'b1; VictimTag = 19'h000AA;
    for (int i = 0; i < 8; i++) VictimLine[i*64 +: 64] = 64'(i);
    MissReq = 1'b1;
    tick();
    MissReq = 1'b0; BusReady = 1'b1;
    VictimLine = '1;                          // must not affect latched data
    for (int i = 0; i < 8; i++) begin
      vec_count++;
      if ({Busy, BusReq, BusWrite, LineWrEn, BusAdr, BusWData} !==
          {1'b1, 1'b1, 1'b1, 1'b0, exp_adr(19'h000AA, 7'h7F, i), 64'(i)})
        begin err_count++; $display("FAIL dirty_wb beat %0d: got %h expected %h", i,
          {Busy, BusReq, BusWrite, LineWrEn, BusAdr, BusWData},
          {1'b1, 1'b1, 1'b1, 1'b0, exp_adr(19'h000AA, 7'h7F, i), 64'(i)}); end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      BusRData = fill_word(i + 8);
      exp_line[i*64 +: 64] = fill_word(i + 8);
      vec_count++;
      if ({BusReq, BusWrite, LineWrEn, BusAdr} !==
          {1'b1, 1'b0, 1'b0, exp_adr(19'h54321, 7'h7F, i)})
        begin err_count++; $display("FAIL dirty_fill beat %0d: got %h expected %h", i,
          {BusReq, BusWrite, LineWrEn, BusAdr},
          {1'b1, 1'b0, 1'b0, exp_adr(19'h54321, 7'h7F, i)}); end
      tick();
    end
    BusReady = 1'b0;                          // cycle t+17
    vec_count++;
    if ({LineWrEn, LRUWriteEn, LineWrWay, LineWrSet, LineWrTag} !==
        {1'b1, 1'b1, 4'b1000, 7'h7F, 19'h54321})
      begin err_count++; $display("FAIL dirty_write: got %h expected %h",
        {LineWrEn, LRUWriteEn, LineWrWay, LineWrSet, LineWrTag},
        {1'b1, 1'b1, 4'b1000, 7'h7F, 19'h54321}); end
    vec_count++;
    if (LineWrData !== exp_line)
      begin err_count++; $display("FAIL dirty_data: got %h expected %h", LineWrData, exp_line); end
    tick();
    vec_count++;
    if ({Done, LineWrEn} !== 2'b10)
      begin err_count++; $display("FAIL dirty_done: got %b expected 10", {Done, LineWrEn}); end
    tick();
    $display("dirty_miss: done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stalls();
    logic [511:0] exp_line;
    int phase, bi, wr_acc, rd_acc, lru_cnt;
    logic rdy;
    phase = 0; bi = 0; wr_acc = 0; rd_acc = 0; lru_cnt = 0;
    MissTag = 19'h00000; MissSet = 7'h2A; VictimWay = 4'b0001;
    VictimDirty = 1'b1; VictimTag = 19'h7FFFF;
    for (int i = 0; i < 8; i++) VictimLine[i*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(i);
    MissReq = 1'b1;
    tick();
    MissReq = 1'b0;
    for (int k = 0; k < 200 && phase < 4; k++) begin
      rdy = (k % 3 == 0);
      BusReady = rdy;
      BusRData = fill_word(bi + 20);
      if (LRUWriteEn) lru_cnt++;
      if (BusReq && BusWrite && rdy) wr_acc++;
      if (BusReq && !BusWrite && rdy) rd_acc++;
      vec_count++;
      case (phase)
        0: if ({BusReq, BusWrite, BusAdr, BusWData} !==
               {1'b1, 1'b1, exp_adr(19'h7FFFF, 7'h2A, bi), 64'hA5A5_0000_0000_0000 + 64'(bi)})
             begin err_count++; $display("FAIL stall_wb cycle %0d beat %0d: got %h expected %h", k, bi,
               {BusReq, BusWrite, BusAdr, BusWData},
               {1'b1, 1'b1, exp_adr(19'h7FFFF, 7'h2A, bi), 64'hA5A5_0000_0000_0000 + 64'(bi)}); end
        1: if ({BusReq, BusWrite, LineWrEn, BusAdr} !==
               {1'b1, 1'b0, 1'b0, exp_adr(19'h00000, 7'h2A, bi)})
             begin err_count++; $display("FAIL stall_fill cycle %0d beat %0d: got %h expected %h", k, bi,
               {BusReq, BusWrite, LineWrEn, BusAdr},
               {1'b1, 1'b0, 1'b0, exp_adr(19'h00000, 7'h2A, bi)}); end
        2: if ({LineWrEn, BusReq} !== 2'b10 || LineWrData !== exp_line)
             begin err_count++; $display("FAIL stall_write: got en %b req %b data %h expected %h",
               LineWrEn, BusReq, LineWrData, exp_line); end
        default: if ({Done, Busy, LineWrEn} !== 3'b110)
             begin err_count++; $display("FAIL stall_done: got %b expected 110",
               {Done, Busy, LineWrEn}); end
      endcase
      tick();
      case (phase)
        0: if (rdy) begin
             if (bi == 7) begin bi = 0; phase = 1; end else bi++;
           end
        1: if (rdy) begin
             exp_line[bi*64 +: 64] = fill_word(bi + 20);
             if (bi == 7) begin bi = 0; phase = 2; end else bi++;
           end
        default: phase++;
      endcase
    end
    BusReady = 1'b0;
    if (LRUWriteEn) lru_cnt++;
    vec_count++;
    if ({wr_acc, rd_acc, lru_cnt} !== {32'd8, 32'd8, 32'd1} || Busy !== 1'b0)
      begin err_count++; $display("FAIL stall_counts: got wr %0d rd %0d lru %0d busy %b expected 8 8 1 0",
        wr_acc, rd_acc, lru_cnt, Busy); end
    $display("stalls: done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_missreq_held();
    int lwe;
    lwe = 0;
    MissTag = 19'h01234; MissSet = 7'h11; VictimWay = 4'b0010;
    VictimDirty = 1'b0; VictimTag = 19'h00BAD;
    MissReq = 1'b1;
    tick();
    MissTag = 19'h66666; VictimDirty = 1'b1;  // ignored while busy
    BusReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      BusRData = fill_word(i + 40);
      vec_count++;
      if ({Busy, BusReq, BusWrite, BusAdr} !== {1'b1, 1'b1, 1'b0, exp_adr(19'h01234, 7'h11, i)})
        begin err_count++; $display("FAIL held_fill beat %0d: got %h expected %h", i,
          {Busy, BusReq, BusWrite, BusAdr}, {1'b1, 1'b1, 1'b0, exp_adr(19'h01234, 7'h11, i)}); end
      tick();
    end
    vec_count++;
    if ({LineWrEn, LineWrTag} !== {1'b1, 19'h01234})
      begin err_count++; $display("FAIL held_write: got %h expected %h",
        {LineWrEn, LineWrTag}, {1'b1, 19'h01234}); end
    tick();
    vec_count++;
    if (Done !== 1'b1)
      begin err_count++; $display("FAIL held_done: got %b expected 1", Done); end
    tick();                                   // idle cycle, MissReq still high
    vec_count++;
    if (Busy !== 1'b0)
      begin err_count++; $display("FAIL held_idle_gap: got busy %b expected 0", Busy); end
    tick();                                   // second replacement, dirty now
    MissReq = 1'b0;
    vec_count++;
    if ({Busy, BusReq, BusWrite, BusAdr} !== {1'b1, 1'b1, 1'b1, exp_adr(19'h00BAD, 7'h11, 0)})
      begin err_count++; $display("FAIL held_second: got %h expected %h",
        {Busy, BusReq, BusWrite, BusAdr}, {1'b1, 1'b1, 1'b1, exp_adr(19'h00BAD, 7'h11, 0)}); end
    for (int j = 0; j < 17; j++) begin
      if (LineWrEn) lwe++;
      tick();
    end
    vec_count++;
    if ({Done, LineWrTag, 32'(lwe)} !== {1'b1, 19'h66666, 32'd1})
      begin err_count++; $display("FAIL held_second_done: got done %b tag %h lwe %0d expected 1 66666 1",
        Done, LineWrTag, lwe); end
    BusReady = 1'b0;
    tick();
    tick();
    vec_count++;
    if (Busy !== 1'b0)
      begin err_count++; $display("FAIL held_no_third: got busy %b expected 0", Busy); end
    $display("missreq_held: done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_fill();
    MissTag = 19'h02222; MissSet = 7'h33; VictimWay = 4'b1000; VictimDirty = 1'b0;
    MissReq = 1'b1;
    tick();
    MissReq = 1'b0; BusReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      BusRData = fill_word(i + 60);
      tick();
    end
    vec_count++;
    if (BusAdr !== exp_adr(19'h02222, 7'h33, 4))
      begin err_count++; $display("FAIL rstmid_pos: got %h expected %h",
        BusAdr, exp_adr(19'h02222, 7'h33, 4)); end
    #2 reset = 1'b1;
    #1;
    vec_count++;
    if ({Busy, BusReq, LineWrEn, Done, LineWrWay, LineWrTag} !== '0)
      begin err_count++; $display("FAIL rstmid_async: got %h expected 0",
        {Busy, BusReq, LineWrEn, Done, LineWrWay, LineWrTag}); end
    for (int j = 0; j < 3; j++) begin
      tick();
      vec_count++;
      if ({Busy, LineWrEn} !== 2'b00)
        begin err_count++; $display("FAIL rstmid_hold %0d: got %b expected 00", j, {Busy, LineWrEn}); end
    end
    reset = 1'b0;
    tick();
    MissTag = 19'h02223; MissReq = 1'b1;
    tick();
    MissReq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      BusRData = fill_word(i + 70);
      vec_count++;
      if ({Busy, BusReq, LineWrEn, BusAdr} !== {1'b1, 1'b1, 1'b0, exp_adr(19'h02223, 7'h33, i)})
        begin err_count++; $display("FAIL rstmid_restart beat %0d: got %h expected %h", i,
          {Busy, BusReq, LineWrEn, BusAdr}, {1'b1, 1'b1, 1'b0, exp_adr(19'h02223, 7'h33, i)}); end
      tick();
    end
    BusReady = 1'b0;
    vec_count++;
    if ({LineWrEn, LineWrData[63:0], LineWrData[511:448]} !== {1'b1, fill_word(70), fill_word(77)})
      begin err_count++; $display("FAIL rstmid_write: got %h expected %h",
        {LineWrEn, LineWrData[63:0], LineWrData[511:448]}, {1'b1, fill_word(70), fill_word(77)}); end
    tick();
    tick();
    $display("reset_mid_fill: done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_beats1();
    logic [511:0] vline, rline;
    for (int i = 0; i < 8; i++) begin
      vline[i*64 +: 64] = 64'hC0DE_0000_0000_0000 + 64'(i);
      rline[i*64 +: 64] = fill_word(i + 90);
    end
    MissTag = 19'h1ABCD; MissSet = 7'h01; VictimWay = 4'b0100;
    VictimDirty = 1'b1; VictimTag = 19'h000AA; VictimLine = vline;
    MissReq1 = 1'b1;
    tick();                                   // t+1: writeback
    MissReq1 = 1'b0; BusReady1 = 1'b1; BusRData1 = rline;
    vec_count++;
    if ({Busy1, BusReq1, BusWrite1, BusAdr1} !== {1'b1, 1'b1, 1'b1, exp_adr(19'h000AA, 7'h01, 0)}
        || BusWData1 !== vline)
      begin err_count++; $display("FAIL b1_wb: got %h data %h expected %h",
        {Busy1, BusReq1, BusWrite1, BusAdr1}, BusWData1,
        {1'b1, 1'b1, 1'b1, exp_adr(19'h000AA, 7'h01, 0)}); end
    tick();                                   // t+2: fill
    vec_count++;
    if ({BusReq1, BusWrite1, LineWrEn1, BusAdr1} !== {1'b1, 1'b0, 1'b0, exp_adr(19'h1ABCD, 7'h01, 0)})
      begin err_count++; $display("FAIL b1_fill: got %h expected %h",
        {BusReq1, BusWrite1, LineWrEn1, BusAdr1}, {1'b1, 1'b0, 1'b0, exp_adr(19'h1ABCD, 7'h01, 0)}); end
    tick();                                   // t+3: array write
    BusReady1 = 1'b0;
    vec_count++;
    if ({LineWrEn1, LRUWriteEn1, BusReq1, LineWrWay1, LineWrTag1} !== {1'b1, 1'b1, 1'b0, 4'b0100, 19'h1ABCD}
        || LineWrData1 !== rline)
      begin err_count++; $display("FAIL b1_write: got %h data %h expected %h",
        {LineWrEn1, LRUWriteEn1, BusReq1, LineWrWay1, LineWrTag1}, LineWrData1,
        {1'b1, 1'b1, 1'b0, 4'b0100, 19'h1ABCD}); end
    tick();                                   // t+4: done
    vec_count++;
    if ({Done1, LineWrEn1, Busy1} !== 3'b101)
      begin err_count++; $display("FAIL b1_done: got %b expected 101", {Done1, LineWrEn1, Busy1}); end
    tick();
    vec_count++;
    if ({Done1, Busy1} !== 2'b00)
      begin err_count++; $display("FAIL b1_idle: got %b expected 00", {Done1, Busy1}); end
    $display("beats1: done");
  endtask

  // -------------------------------------------------------------------------
  initial begin
    MissReq = 1'b0; MissReq1 = 1'b0; MissTag = '0; MissSet = '0;
    VictimWay = '0; VictimDirty = 1'b0; VictimTag = '0; VictimLine = '0;
    BusReady = 1'b0; BusReady1 = 1'b0; BusRData = '0; BusRData1 = '0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stalls();
    test_missreq_held();
    test_reset_mid_fill();
    test_beats1();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
